// File: rtl/opcode_pkg.sv
// Opcode and one-hot control encodings shared by the issue stage and the opcode decoder.
package opcode_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  localparam logic [3:0] CS_ADD = 4'b0001;
  localparam logic [3:0] CS_SUB = 4'b0010;
  localparam logic [3:0] CS_MUL = 4'b0100;
  localparam logic [3:0] CS_DIV = 4'b1000;

  typedef struct packed {
    op_t  op;
    logic legal;
  } cs_dec_t;

  // Anything other than exactly one set bit is illegal; op is don't-care then.
  function automatic cs_dec_t cs_to_op(input logic [3:0] cs);
    cs_dec_t r;
    r.op    = OP_ADD;
    r.legal = 1'b1;
    case (cs)
      CS_ADD:  r.op = OP_ADD;
      CS_SUB:  r.op = OP_SUB;
      CS_MUL:  r.op = OP_MUL;
      CS_DIV:  r.op = OP_DIV;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/op_fifo.sv
// Small synchronous FIFO of opcodes; pointers wrap naturally since DEPTH is a power of two.
module op_fifo
  import opcode_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  op_t                      data_i,
  output op_t                      data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  op_t           mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/opcode_issuer.sv
// Issue stage: checks one-hot ALU requests, queues legal opcodes and hands them
// downstream over valid/ready; rejected requests pulse illegal and bump a saturating counter.
module opcode_issuer
  import opcode_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ctrl_valid,
  output logic                   ctrl_ready,
  input  logic [3:0]             control_signal,
  output logic                   opcode_valid,
  input  logic                   opcode_ready,
  output logic [1:0]             opcode,
  output logic                   illegal,
  output logic [ERR_CNT_W-1:0]   illegal_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } state_t;

  state_t               state_q;
  logic                 illegal_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  cs_dec_t       dec;
  logic          accept;
  logic          push;
  logic          pop;
  op_t           fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  assign dec    = cs_to_op(control_signal);
  assign accept = ctrl_valid && ctrl_ready;
  assign push   = accept && dec.legal;
  assign pop    = opcode_valid && opcode_ready;

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (dec.op),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Ready depends only on registered state; rst masks it so nothing is taken during reset.
  assign ctrl_ready    = !rst && (state_q != ST_FULL) && !fifo_full;
  assign opcode_valid  = (state_q != ST_EMPTY);
  assign opcode        = fifo_empty ? OP_ADD : fifo_head;
  assign illegal       = illegal_q;
  assign illegal_count = err_cnt_q;
  assign level         = fifo_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      illegal_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      illegal_q <= accept && !dec.legal;
      if (accept && !dec.legal && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
      case (state_q)
        ST_EMPTY: begin
          if (push) state_q <= ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (push && !pop && (fifo_level == LW'(DEPTH - 1))) begin
            state_q <= ST_FULL;
          end else if (pop && !push && (fifo_level == LW'(1))) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) state_q <= ST_PARTIAL;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule
